// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory stage of the pipeline. It drives a request/acknowledge data-memory
// port, stalls the upstream pipeline while an access waits for dmem_ack,
// aborts an access that waits too long, and registers the results into the
// MEM/WB pipeline register.
//
// Parameters
//   WAIT_LIMIT         maximum WAIT-state cycles without dmem_ack before the
//                      access is aborted (1..255)
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   mem_to_reg_in      writeback selects memory data
//   reg_write_in       instruction writes the register file
//   mem_write_in       store request
//   mem_read_in        load request
//   address_in [31:0]  ALU result (memory address or writeback value)
//   rt_in      [31:0]  store data
//   reg_dest_in [4:0]  destination register
//   dmem_req/we/addr/wdata   data-memory request side
//   dmem_ack/rdata           data-memory response side
//   mem_stall          freezes PC and all upstream pipeline registers
//   mem_err            sticky timeout flag, cleared only by rst
//   wb_*               registered MEM/WB outputs
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        mem_write_in,
  input  logic        mem_read_in,
  input  logic [31:0] address_in,
  input  logic [31:0] rt_in,
  input  logic [4:0]  reg_dest_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        wb_mem_to_reg_out,
  output logic        wb_reg_write_out,
  output logic [31:0] wb_read_data_out,
  output logic [31:0] wb_alu_res_out,
  output logic [4:0]  wb_reg_dest_out
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Counter value on which a still-unacknowledged WAIT cycle aborts.
  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        mem_err_nxt;
  logic        access;
  logic        abort;
  logic        read_done;

  // A store wins when both request bits are set, so dmem_we simply follows
  // mem_write_in; the address and write data pass straight through.
  assign access     = mem_read_in | mem_write_in;
  assign dmem_we    = mem_write_in;
  assign dmem_addr  = address_in;
  assign dmem_wdata = rt_in;

  // The request stays up for the whole WAIT period because upstream holds
  // the instruction stable while we stall. Reset forces it low even in WAIT.
  assign dmem_req  = ~rst & (((state == IDLE) & access) | (state == WAIT));
  assign mem_stall = dmem_req & ~dmem_ack & ~abort;

  // Only a completed pure load returns memory data; stores (including the
  // read+write combination) hand zero to writeback.
  assign read_done = dmem_req & dmem_ack & mem_read_in & ~mem_write_in;

  // Next-state logic. Ack is tested before the timeout so an ack arriving on
  // the last allowed cycle still completes normally.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        if (access && !dmem_ack) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = 8'd0;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_nxt = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          abort       = ~rst;
          mem_err_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, wait counter and sticky error flag. Reset abandons any access in
  // flight without flagging an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  // MEM/WB pipeline register. A stalled or aborted cycle inserts a bubble so
  // the waiting or faulting instruction never reaches the register file.
  always_ff @(posedge clk) begin
    if (rst || mem_stall || abort) begin
      wb_mem_to_reg_out <= 1'b0;
      wb_reg_write_out  <= 1'b0;
      wb_read_data_out  <= 32'd0;
      wb_alu_res_out    <= 32'd0;
      wb_reg_dest_out   <= 5'd0;
    end else begin
      wb_mem_to_reg_out <= mem_to_reg_in;
      wb_reg_write_out  <= reg_write_in;
      wb_read_data_out  <= read_done ? dmem_rdata : 32'd0;
      wb_alu_res_out    <= address_in;
      wb_reg_dest_out   <= reg_dest_in;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage with WAIT_LIMIT = 4. Each instruction is
// applied for as many cycles as the memory takes; the expected MEM/WB
// contents for every edge are queued when the stimulus is driven and popped
// and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int WL = 4;

  typedef struct {
    logic        mtr;
    logic        rw;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dest;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in;
  logic [31:0] address_in, rt_in;
  logic [4:0]  reg_dest_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall, mem_err;
  logic        wb_mem_to_reg_out, wb_reg_write_out;
  logic [31:0] wb_read_data_out, wb_alu_res_out;
  logic [4:0]  wb_reg_dest_out;

  int  n_cmp  = 0;
  int  n_fail = 0;
  wb_t exp_q[$];

  mem_stage #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
    .address_in(address_in), .rt_in(rt_in), .reg_dest_in(reg_dest_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_err(mem_err),
    .wb_mem_to_reg_out(wb_mem_to_reg_out), .wb_reg_write_out(wb_reg_write_out),
    .wb_read_data_out(wb_read_data_out), .wb_alu_res_out(wb_alu_res_out),
    .wb_reg_dest_out(wb_reg_dest_out)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pops the expected MEM/WB record for the edge just taken and compares it.
  task automatic checkWb(input string tag);
    wb_t e;
    e = exp_q.pop_front();
    checkOutput({tag, ".wb_mtr"},  32'(wb_mem_to_reg_out), 32'(e.mtr));
    checkOutput({tag, ".wb_rw"},   32'(wb_reg_write_out),  32'(e.rw));
    checkOutput({tag, ".wb_rd"},   wb_read_data_out,       e.rd);
    checkOutput({tag, ".wb_alu"},  wb_alu_res_out,         e.alu);
    checkOutput({tag, ".wb_dest"}, 32'(wb_reg_dest_out),   32'(e.dest));
  endtask

  // Applies one instruction until it leaves the stage. ack_cyc is the request
  // cycle on which memory acknowledges (0 = never, which must time out).
  // Called just after a rising edge; returns just after a rising edge.
  task automatic applyStimulus(input logic mtr, input logic rw, input logic mw,
                               input logic mr, input logic [31:0] addr,
                               input logic [31:0] rt, input logic [4:0] dest,
                               input int ack_cyc, input logic [31:0] rdata,
                               input string tag);
    logic acc;
    logic ack;
    bit   ab;
    int   last;
    wb_t  e;
    acc = mw | mr;
    mem_to_reg_in = mtr; reg_write_in = rw; mem_write_in = mw; mem_read_in = mr;
    address_in = addr; rt_in = rt; reg_dest_in = dest;
    if (!acc)            last = 1;
    else if (ack_cyc > 0) last = ack_cyc;
    else                  last = WL + 1;
    for (int c = 1; c <= last; c++) begin
      ack = acc && (c == ack_cyc);
      ab  = acc && (ack_cyc == 0) && (c == WL + 1);
      dmem_ack   = ack;
      dmem_rdata = ack ? rdata : 32'h0BAD0BAD;
      if (c < last || ab) begin
        e = '{mtr: 1'b0, rw: 1'b0, rd: 32'd0, alu: 32'd0, dest: 5'd0};
      end else begin
        e = '{mtr: mtr, rw: rw, rd: (mr && !mw) ? rdata : 32'd0, alu: addr, dest: dest};
      end
      exp_q.push_back(e);
      #1;
      checkOutput({tag, ".req"},   32'(dmem_req),  32'(acc));
      checkOutput({tag, ".stall"}, 32'(mem_stall), 32'(acc && c < last));
      if (acc) begin
        checkOutput({tag, ".we"},    32'(dmem_we), 32'(mw));
        checkOutput({tag, ".addr"},  dmem_addr,    addr);
        checkOutput({tag, ".wdata"}, dmem_wdata,   rt);
      end
      @(posedge clk);
      #1;
      checkWb(tag);
    end
    dmem_ack = 1'b0;
  endtask

  task automatic applyNop(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 32'h0, tag);
  endtask

  initial begin
    rst = 1'b1;
    mem_to_reg_in = 1'b1; reg_write_in = 1'b1; mem_write_in = 1'b0; mem_read_in = 1'b1;
    address_in = 32'h40; rt_in = 32'h0; reg_dest_in = 5'd3;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;

    // Reset held two cycles with a pending load and no ack.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst.req",   32'(dmem_req),  32'd0);
      checkOutput("rst.stall", 32'(mem_stall), 32'd0);
      @(posedge clk);
    end
    #1;
    checkOutput("rst.err", 32'(mem_err), 32'd0);
    exp_q.push_back('{mtr: 1'b0, rw: 1'b0, rd: 32'd0, alu: 32'd0, dest: 5'd0});
    checkWb("rst");
    rst = 1'b0;

    // Non-memory instruction passes through in one cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5, 0, 32'h0, "alu");
    // Zero-wait load.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd7, 1, 32'hDEADBEEF, "load0");
    // Load acknowledged on the 4th request cycle: three bubbles then data.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 5'd9, 4, 32'hCAFEF00D, "load4");
    // Read and write together behave as a store.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 32'h12345678, 5'd0, 2, 32'h55AA55AA, "store_rw");
    // Ack on the last allowed WAIT cycle still completes.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h48, 32'h0, 5'd11, WL + 1, 32'h13572468, "load_edge");
    checkOutput("noerr", 32'(mem_err), 32'd0);

    // Short random mix of nops, loads and stores.
    for (int i = 0; i < 8; i++) begin
      int   kind;
      int   lat;
      logic [31:0] a;
      logic [31:0] d;
      logic [4:0]  r;
      kind = $urandom_range(0, 2);
      lat  = $urandom_range(1, 3);
      a = $urandom; d = $urandom; r = 5'($urandom_range(1, 31));
      case (kind)
        0:       applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, a, d, r, 0,   32'h0, "rnd_alu");
        1:       applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, a, d, r, lat, d,     "rnd_load");
        default: applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, a, d, r, lat, d,     "rnd_store");
      endcase
    end
    checkOutput("noerr2", 32'(mem_err), 32'd0);

    // Timeout: five request cycles, four stalls, a bubble, sticky error.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hA0, 32'h0, 5'd12, 0, 32'h0, "timeout");
    checkOutput("err.set", 32'(mem_err), 32'd1);
    applyNop("post_to");
    applyNop("post_to2");
    checkOutput("err.hold", 32'(mem_err), 32'd1);

    // Reset in the middle of a WAIT: access abandoned, late ack ignored.
    mem_to_reg_in = 1'b1; reg_write_in = 1'b1; mem_write_in = 1'b0; mem_read_in = 1'b1;
    address_in = 32'hB0; reg_dest_in = 5'd4; dmem_ack = 1'b0;
    #1;
    checkOutput("mid.stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    checkOutput("mid.stall2", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid.rst_req",   32'(dmem_req),  32'd0);
    checkOutput("mid.rst_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    checkOutput("mid.err_clr", 32'(mem_err), 32'd0);
    checkOutput("mid.wb_rw",   32'(wb_reg_write_out), 32'd0);
    rst = 1'b0;
    mem_to_reg_in = 1'b0; reg_write_in = 1'b0; mem_read_in = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    checkOutput("late.req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    checkOutput("late.err", 32'(mem_err), 32'd0);
    checkOutput("late.rd",  wb_read_data_out, 32'd0);
    dmem_ack = 1'b0;
    // State must be back in IDLE: a fresh load stalls once then completes.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hC0, 32'h0, 5'd6, 2, 32'h600DF00D, "after_rst");
    checkOutput("final.err", 32'(mem_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter: WAIT_LIMIT, default 15, maximum WAIT-state cycles without dmem_ack before an access is aborted (legal 1..255).
REQ-002 SHALL have one clock and a synchronous, active-high reset. Ports are listed in REQ-003 to REQ-021.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 mem_to_reg_in  in  1  load result selects memory data at writeback.
REQ-006 reg_write_in  in  1  instruction writes the register file.
REQ-007 mem_write_in  in  1  store request.
REQ-008 mem_read_in  in  1  load request.
REQ-009 address_in  in  32  ALU result; memory address or writeback value.
REQ-010 rt_in  in  32  store data.
REQ-011 reg_dest_in  in  5  destination register.
REQ-012 dmem_req  out  1  data-memory request.
REQ-013 dmem_we  out  1  1 = write, 0 = read; valid while dmem_req=1.
REQ-014 dmem_addr  out  32  memory address.
REQ-015 dmem_wdata  out  32  memory write data.
REQ-016 dmem_ack  in  1  access complete this cycle.
REQ-017 dmem_rdata  in  32  read data, valid with dmem_ack.
REQ-018 mem_stall  out  1  freezes PC and all upstream pipeline registers.
REQ-019 mem_err  out  1  sticky timeout flag.
REQ-020 wb_mem_to_reg_out, wb_reg_write_out  out  1 each  registered controls to writeback.
REQ-021 wb_read_data_out, wb_alu_res_out  out  32 each; wb_reg_dest_out  out  5. All registered to writeback.

Function
REQ-022 SHALL have access = mem_read_in | mem_write_in. When both are set, the access SHALL be treated as a write.
REQ-023 SHALL implement an FSM with states IDLE and WAIT.
REQ-024 dmem_req SHALL be 1 whenever rst=0 and either (IDLE and access) or WAIT holds. This output is combinational.
REQ-025 dmem_addr SHALL equal address_in, dmem_wdata SHALL equal rt_in, and dmem_we SHALL equal mem_write_in. These outputs are combinational.
REQ-026 mem_stall SHALL equal dmem_req & ~dmem_ack & ~abort. It is combinational and SHALL be 0 during rst.
REQ-027 IDLE with access and dmem_ack=1 (zero-wait): the access completes this cycle and the state remains IDLE.
REQ-028 IDLE with access and dmem_ack=0: the next state SHALL be WAIT with the wait counter cleared to 0.
REQ-029 WAIT with dmem_ack=1: the access completes this cycle and the next state SHALL be IDLE. Ack is checked before timeout.
REQ-030 WAIT with dmem_ack=0 and counter < WAIT_LIMIT-1: the counter SHALL increment and the state remains WAIT.
REQ-031 WAIT with dmem_ack=0 and counter = WAIT_LIMIT-1: abort=1 this cycle, mem_err SHALL be set at the edge, and the next state SHALL be IDLE.
REQ-032 mem_err SHALL remain 1 until rst.
REQ-033 On each edge with mem_stall=1, the MEM_WB outputs SHALL load a bubble: wb_reg_write_out=0, wb_mem_to_reg_out=0, wb_reg_dest_out=0, and both data outputs 0.
REQ-034 On each edge with mem_stall=0 and no abort, the MEM_WB outputs SHALL load the inputs:
- wb_alu_res_out = address_in.
- wb_read_data_out = dmem_rdata if a read completes this cycle, else 0.
REQ-035 An aborted access SHALL load a bubble, so the faulting instruction never writes the register file.
REQ-036 The upstream stage holds its inputs stable while mem_stall=1, so no request is re-issued for the same instruction after completion.
REQ-037 A non-memory instruction SHALL pass through with 1-cycle latency and no stall.

Reset
REQ-038 On a clk edge with rst=1:
- state SHALL be IDLE and the counter 0.
- mem_err SHALL be 0.
- all wb_* outputs SHALL be 0.
REQ-039 While rst=1, dmem_req and mem_stall SHALL be 0 regardless of state or inputs.
REQ-040 Reset asserted mid-access (WAIT state) SHALL abandon the access without setting mem_err. A late dmem_ack after reset SHALL be ignored.

Verification
REQ-041 Hold rst=1 for 2 cycles with mem_read_in=1 and dmem_ack=0 -> dmem_req=0, mem_stall=0, all wb_* outputs 0, mem_err=0.
REQ-042 Apply reg_write_in=1, address_in=0x00000010, reg_dest_in=5, no access -> next edge gives wb_alu_res_out=0x10, wb_reg_dest_out=5, wb_reg_write_out=1; mem_stall stays 0.
REQ-043 Apply a load at address 0x40 with dmem_ack=1 and dmem_rdata=0xDEADBEEF in the same cycle -> mem_stall=0; next edge gives wb_read_data_out=0xDEADBEEF and wb_mem_to_reg_out=1.
REQ-044 Apply a load with dmem_ack arriving on the 4th request cycle -> mem_stall=1 for 3 cycles and wb_reg_write_out=0 for 3 edges, then the data loads.
REQ-045 Apply a store with rt_in=0x12345678 and mem_read_in=1 simultaneously -> dmem_we=1 and dmem_wdata=0x12345678; wb_read_data_out=0 after ack.
REQ-046 With WAIT_LIMIT=4, apply a load with ack never asserted -> dmem_req high 5 cycles, mem_stall high 4, a bubble is loaded, mem_err=1 and held until rst.
